// File: rtl/ifetch_buf_if.sv
// Fetch bundle: imem request/response channels plus the decoder-facing head and control.
// master = fetch unit, slave = imem + decoder side.
interface ifetch_buf_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] o;
  logic [AW-1:0] o_pc;
  logic          o_valid;
  logic          adv;
  logic          pcwe;
  logic [AW-1:0] pc_tgt;
  logic          h;
  logic          halted;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data,
    output o, o_pc, o_valid, halted,
    input  adv, pcwe, pc_tgt, h
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data,
    input  o, o_pc, o_valid, halted,
    output adv, pcwe, pc_tgt, h
  );
endinterface

// File: rtl/ifetch_buf.sv
// Instruction prefetch buffer: in-order imem reads into a DEPTH-entry FIFO; request accept N -> o_valid N+2 (N+1 with IFETCH_BYPASS_EN).
// Requests are credit-limited (buffered + in-flight <= DEPTH); redirect/halt flush the FIFO and drop in-flight responses.
module ifetch_buf #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  ifetch_buf_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

  logic [AW-1:0] fpc_q, fpc_d;
  logic [AW-1:0] rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          halted_q, halted_d;
  logic [DW-1:0] mem_dat_q [DEPTH];
  logic [DW-1:0] mem_dat_d [DEPTH];
  logic [AW-1:0] mem_pc_q  [DEPTH];
  logic [AW-1:0] mem_pc_d  [DEPTH];

  logic          rsp_fire, rsp_drop, byp;
  logic          o_vld, pop, pop_fifo, halt_now, redirect, flush, push;
  logic          req_vld, req_fire;
  logic [CW:0]   occupancy;
  logic [DW-1:0] o_dat;
  logic [AW-1:0] o_pc_dat;

  always_comb begin
    // Responses with nothing outstanding (stale, from before a reset) are ignored.
    rsp_fire = bus.rsp_valid && (inflight_q != '0);
    rsp_drop = rsp_fire && (drop_q != '0);
`ifdef IFETCH_BYPASS_EN
    byp = rsp_fire && !rsp_drop && (count_q == '0) && !halted_q;
`else
    byp = 1'b0;
`endif
    o_vld    = !halted_q && ((count_q != '0) || byp);
    pop      = o_vld && bus.adv;
    pop_fifo = pop && (count_q != '0);
    halt_now = pop && bus.h;
    redirect = bus.pcwe && !halted_q && !halt_now;
    flush    = halt_now || redirect;
    push     = rsp_fire && !rsp_drop && !flush && !(byp && pop);

    occupancy = {1'b0, count_q} + {1'b0, inflight_q};
    req_vld   = rst_n && !halted_q && !bus.pcwe && (occupancy < CREDITS);
    req_fire  = req_vld && bus.req_ready;

    o_dat    = '0;
    o_pc_dat = '0;
    if (byp) begin
      o_dat    = bus.rsp_data;
      o_pc_dat = rsp_pc_q;
    end else if (o_vld) begin
      o_dat    = mem_dat_q[rd_ptr_q];
      o_pc_dat = mem_pc_q[rd_ptr_q];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (req_fire) inflight_d = inflight_d + C_ONE;
    if (rsp_fire) inflight_d = inflight_d - C_ONE;

    // On a flush everything still outstanding after this cycle must be discarded.
    drop_d = drop_q;
    if (flush)         drop_d = inflight_d;
    else if (rsp_drop) drop_d = drop_q - C_ONE;

    fpc_d = fpc_q;
    if (redirect)      fpc_d = bus.pc_tgt;
    else if (req_fire) fpc_d = fpc_q + AW'(1);

    rsp_pc_d = rsp_pc_q;
    if (redirect)                   rsp_pc_d = bus.pc_tgt;
    else if (rsp_fire && !rsp_drop) rsp_pc_d = rsp_pc_q + AW'(1);

    halted_d  = halted_q || halt_now;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    mem_dat_d = mem_dat_q;
    mem_pc_d  = mem_pc_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_dat_d[wr_ptr_q] = bus.rsp_data;
        mem_pc_d[wr_ptr_q]  = rsp_pc_q;
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = count_d + C_ONE;
      end
      if (pop_fifo) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        count_d  = count_d - C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= '0;
      rsp_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      halted_q   <= 1'b0;
      mem_dat_q  <= '{default: '0};
      mem_pc_q   <= '{default: '0};
    end else begin
      fpc_q      <= fpc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
      mem_dat_q  <= mem_dat_d;
      mem_pc_q   <= mem_pc_d;
    end
  end

  assign bus.req_valid = req_vld;
  assign bus.req_addr  = fpc_q;
  assign bus.o         = o_dat;
  assign bus.o_pc      = o_pc_dat;
  assign bus.o_valid   = o_vld;
  assign bus.halted    = halted_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && (count_q == C_FULL)));
      assert (!(bus.rsp_valid && (inflight_q == '0)));
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_buf.sv
// Directed bench for ifetch_buf with a latency-configurable imem model; expectations adapt to IFETCH_BYPASS_EN.
module tb_ifetch_buf;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifetch_buf_if #(.DW(DW), .AW(AW)) bus ();
  ifetch_buf #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vecs = 0;
  int fails = 0;
  int lat = 1;
  int acc_cnt = 0;
  bit pv [8];
  logic [7:0] pa [8];

  function automatic logic [15:0] imem(input logic [7:0] a);
    case (a)
      8'h00: imem = 16'h0401;
      8'h01: imem = 16'h0502;
      8'h02: imem = 16'h2C12;
      8'h03: imem = 16'h0000;
      8'h04: imem = 16'h0001;
      default: imem = {8'hA0, a};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: record acceptance, advance the imem delay line, present its head response.
  task automatic step();
    bit acc;
    logic [7:0] a;
    #1;
    acc = bus.req_valid && bus.req_ready;
    a   = bus.req_addr;
    if (acc) acc_cnt++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      pv[i] = pv[i+1];
      pa[i] = pa[i+1];
    end
    pv[7] = 1'b0;
    if (acc) begin
      pv[lat-1] = 1'b1;
      pa[lat-1] = a;
    end
    bus.rsp_valid = pv[0];
    bus.rsp_data  = pv[0] ? imem(pa[0]) : 16'h0000;
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    lat = l;
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      pa[i] = 8'h00;
    end
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.adv = 1'b0;
    bus.pcwe = 1'b0;
    bus.h = 1'b0;
    bus.pc_tgt = '0;
    acc_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [7:0] pc, input string tag);
    int n = 0;
    settle();
    while (!(bus.o_valid && bus.o_pc == pc) && n < 30) begin
      step();
      settle();
      n++;
    end
    chk(tag, 32'(bus.o_valid && bus.o_pc == pc), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    settle();
    while (!bus.o_valid && n < 30) begin
      step();
      settle();
      n++;
    end
    chk(tag, 32'(bus.o_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_data = '0;
    bus.adv = 1'b0;
    bus.pcwe = 1'b0;
    bus.h = 1'b0;
    bus.pc_tgt = '0;
    #2;
    chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_req_addr",  32'(bus.req_addr),  32'd0);
    chk("rst_o",         32'(bus.o),         32'd0);
    chk("rst_o_pc",      32'(bus.o_pc),      32'd0);
    chk("rst_o_valid",   32'(bus.o_valid),   32'd0);
    chk("rst_halted",    32'(bus.halted),    32'd0);

    // Streaming with 1-cycle imem, consumer always ready.
    do_reset(1);
    bus.adv = 1'b1;
    for (int k = 0; k < 9; k++) begin
      settle();
      chk("stream_req_valid", 32'(bus.req_valid), 32'd1);
      chk("stream_req_addr",  32'(bus.req_addr),  32'(k));
      if (k >= 2 - BL) begin
        chk("stream_o_valid", 32'(bus.o_valid), 32'd1);
        chk("stream_o",       32'(bus.o),       32'(imem(8'(k - 2 + BL))));
        chk("stream_o_pc",    32'(bus.o_pc),    32'(k - 2 + BL));
      end else begin
        chk("stream_o_valid_early", 32'(bus.o_valid), 32'd0);
        chk("stream_o_nop",         32'(bus.o),       32'd0);
      end
      step();
    end

    // Consumer stalled: credits stop fetch at DEPTH words.
    do_reset(1);
    for (int k = 0; k < 10; k++) step();
    settle();
    chk("stall_accepts",   32'(acc_cnt),       32'(DEPTH));
    chk("stall_req_valid", 32'(bus.req_valid), 32'd0);
    chk("stall_o",         32'(bus.o),         32'h0401);
    chk("stall_o_pc",      32'(bus.o_pc),      32'd0);
    chk("stall_o_valid",   32'(bus.o_valid),   32'd1);
    bus.adv = 1'b1;
    settle();
    chk("full_pop_req_valid", 32'(bus.req_valid), 32'd0);
    step();
    settle();
    chk("pop1_o",         32'(bus.o),         32'h0502);
    chk("pop1_o_pc",      32'(bus.o_pc),      32'd1);
    chk("pop1_req_valid", 32'(bus.req_valid), 32'd1);
    chk("pop1_req_addr",  32'(bus.req_addr),  32'd4);
    step();
    settle();
    chk("pop2_o_pc",     32'(bus.o_pc),     32'd2);
    chk("pop2_req_addr", 32'(bus.req_addr), 32'd5);

    // Redirect with several responses outstanding (3-cycle imem).
    do_reset(3);
    bus.adv = 1'b1;
    wait_pc(8'h02, "redir_reach_pc2");
    bus.pcwe = 1'b1;
    bus.pc_tgt = 8'h40;
    settle();
    chk("redir_req_blocked", 32'(bus.req_valid), 32'd0);
    step();
    bus.pcwe = 1'b0;
    settle();
    chk("redir_flushed", 32'(bus.o_valid), 32'd0);
    wait_valid("redir_resume");
    chk("redir_o_pc0", 32'(bus.o_pc), 32'h40);
    chk("redir_o0",    32'(bus.o),    32'(imem(8'h40)));
    step();
    settle();
    chk("redir_o_valid1", 32'(bus.o_valid), 32'd1);
    chk("redir_o_pc1",    32'(bus.o_pc),    32'h41);
    chk("redir_o1",       32'(bus.o),       32'(imem(8'h41)));

    // Address wrap after redirect to 0xFE.
    do_reset(1);
    bus.adv = 1'b1;
    wait_pc(8'h00, "wrap_reach_pc0");
    bus.pcwe = 1'b1;
    bus.pc_tgt = 8'hFE;
    settle();
    step();
    bus.pcwe = 1'b0;
    wait_valid("wrap_resume");
    for (int i = 0; i < 4; i++) begin
      chk("wrap_o_valid", 32'(bus.o_valid), 32'd1);
      chk("wrap_o_pc",    32'(bus.o_pc),    32'((8'hFE + i) & 8'hFF));
      chk("wrap_o",       32'(bus.o),       32'(imem(8'((8'hFE + i) & 8'hFF))));
      step();
      settle();
    end

    // HALT on head 0x0001, with a simultaneous redirect that must lose.
    do_reset(1);
    bus.adv = 1'b1;
    wait_pc(8'h04, "halt_reach_pc4");
    chk("halt_head", 32'(bus.o), 32'h0001);
    bus.h = 1'b1;
    bus.pcwe = 1'b1;
    bus.pc_tgt = 8'h40;
    settle();
    step();
    bus.h = 1'b0;
    bus.pcwe = 1'b0;
    for (int k = 0; k < 20; k++) begin
      settle();
      chk("halt_halted",    32'(bus.halted),    32'd1);
      chk("halt_o_valid",   32'(bus.o_valid),   32'd0);
      chk("halt_req_valid", 32'(bus.req_valid), 32'd0);
      step();
    end

    // Asynchronous reset pulse mid-cycle.
    #1;
    bus.rsp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("arst_req_addr",  32'(bus.req_addr),  32'd0);
    chk("arst_o",         32'(bus.o),         32'd0);
    chk("arst_o_pc",      32'(bus.o_pc),      32'd0);
    chk("arst_o_valid",   32'(bus.o_valid),   32'd0);
    chk("arst_halted",    32'(bus.halted),    32'd0);
    do_reset(1);
    bus.adv = 1'b1;
    settle();
    chk("restart_req_valid", 32'(bus.req_valid), 32'd1);
    chk("restart_req_addr",  32'(bus.req_addr),  32'd0);
    step();
    step();
    settle();
    chk("restart_o_valid", 32'(bus.o_valid), 32'd1);
    chk("restart_o_pc",    32'(bus.o_pc),    32'(BL));
    chk("restart_o",       32'(bus.o),       32'(imem(8'(BL))));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
